// File: rtl/router_fsm.sv
// Packet write controller for the 1x3 router: decodes the header destination,
// sequences header/payload/parity loading into the selected FIFO and stalls the source.
//
// state | meaning
// DA    | DECODE_ADDRESS: waiting for a header with a valid destination
// LFD   | LOAD_FIRST_DATA: header byte written to the selected FIFO
// LD    | LOAD_DATA: payload bytes streaming into the FIFO
// WTE   | WAIT_TILL_EMPTY: destination FIFO still holds an earlier packet
// FFS   | FIFO_FULL_STATE: destination FIFO full, source stalled
// LAF   | LOAD_AFTER_FULL: byte held during the stall is written
// LP    | LOAD_PARITY: parity byte written
// CPE   | CHECK_PARITY_ERROR: datapath parity registers cleared
module router_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [1:0] addr_q
);

    localparam logic [2:0] S_DA  = 3'd0;
    localparam logic [2:0] S_LFD = 3'd1;
    localparam logic [2:0] S_LD  = 3'd2;
    localparam logic [2:0] S_WTE = 3'd3;
    localparam logic [2:0] S_FFS = 3'd4;
    localparam logic [2:0] S_LAF = 3'd5;
    localparam logic [2:0] S_LP  = 3'd6;
    localparam logic [2:0] S_CPE = 3'd7;

    logic [2:0] r_state;
    logic [1:0] r_addr;
    logic [2:0] w_next_state;
    logic [1:0] w_next_addr;

    logic w_hdr_valid;
    logic w_hdr_empty;
    logic w_sel_full;
    logic w_sel_empty;
    logic w_sel_srst;

    // Address 3 has no FIFO; the muxes return 0 for it so no flag is ever read out of range.
    always_comb begin
        w_hdr_empty = 1'b0;
        case (data_in)
            2'd0:    w_hdr_empty = fifo_empty[0];
            2'd1:    w_hdr_empty = fifo_empty[1];
            2'd2:    w_hdr_empty = fifo_empty[2];
            default: w_hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_sel_full  = 1'b0;
        w_sel_empty = 1'b0;
        w_sel_srst  = 1'b0;
        case (r_addr)
            2'd0: begin
                w_sel_full  = fifo_full[0];
                w_sel_empty = fifo_empty[0];
                w_sel_srst  = soft_reset[0];
            end
            2'd1: begin
                w_sel_full  = fifo_full[1];
                w_sel_empty = fifo_empty[1];
                w_sel_srst  = soft_reset[1];
            end
            2'd2: begin
                w_sel_full  = fifo_full[2];
                w_sel_empty = fifo_empty[2];
                w_sel_srst  = soft_reset[2];
            end
            default: begin
                w_sel_full  = 1'b0;
                w_sel_empty = 1'b0;
                w_sel_srst  = 1'b0;
            end
        endcase
    end

    assign w_hdr_valid = pkt_valid && (data_in != 2'd3);

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        if ((r_state != S_DA) && w_sel_srst) begin
            w_next_state = S_DA;
        end else begin
            case (r_state)
                S_DA: begin
                    if (w_hdr_valid) begin
                        w_next_addr  = data_in;
                        w_next_state = w_hdr_empty ? S_LFD : S_WTE;
                    end
                end
                S_WTE: begin
                    if (w_sel_empty)
                        w_next_state = S_LFD;
                end
                S_LFD: begin
                    w_next_state = S_LD;
                end
                // Full wins over end-of-packet so the last byte is not lost.
                S_LD: begin
                    if (w_sel_full)
                        w_next_state = S_FFS;
                    else if (!pkt_valid)
                        w_next_state = S_LP;
                end
                S_FFS: begin
                    if (!w_sel_full)
                        w_next_state = S_LAF;
                end
                S_LAF: begin
                    if (parity_done)
                        w_next_state = S_DA;
                    else if (low_pkt_valid)
                        w_next_state = S_LP;
                    else
                        w_next_state = S_LD;
                end
                S_LP: begin
                    w_next_state = S_CPE;
                end
                S_CPE: begin
                    w_next_state = w_sel_full ? S_FFS : S_DA;
                end
                default: begin
                    w_next_state = S_DA;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_DA;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
        end
    end

    assign detect_add    = (r_state == S_DA);
    assign lfd_state     = (r_state == S_LFD);
    assign ld_state      = (r_state == S_LD);
    assign laf_state     = (r_state == S_LAF);
    assign full_state    = (r_state == S_FFS);
    assign rst_int_reg   = (r_state == S_CPE);
    assign write_enb_reg = (r_state == S_LD) || (r_state == S_LFD) ||
                           (r_state == S_LP) || (r_state == S_LAF);
    assign busy          = (r_state == S_LFD) || (r_state == S_LP)  ||
                           (r_state == S_FFS) || (r_state == S_LAF) ||
                           (r_state == S_WTE) || (r_state == S_CPE);
    assign addr_q        = r_addr;

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-level write controller for the 1x3 router. Sits between the input register/parity block and the three per-destination output FIFOs.
- Decodes the destination from the header byte and sequences header, payload and parity loading.
- Stalls the source while the selected FIFO is occupied or full, and aborts the packet on a destination soft reset.
- All control outputs are Moore decodes of a single state register.

Parameters:
- NUM_DEST, 3, number of destination FIFOs. Fixed at 3; destination address is 2 bits and 2'b11 is invalid.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous reset, active-high
- pkt_valid  input  1  source holds packet bytes valid; deasserts on the parity byte
- data_in  input  2  header bits [1:0] = destination address; sampled only in DECODE_ADDRESS
- fifo_full  input  3  full flag per destination FIFO
- fifo_empty  input  3  empty flag per destination FIFO
- soft_reset  input  3  per-destination soft reset (timeout) pulse
- parity_done  input  1  parity byte has been registered by the datapath
- low_pkt_valid  input  1  pkt_valid fell while the FSM was in FIFO_FULL_STATE
- detect_add  output  1  high in DECODE_ADDRESS
- lfd_state  output  1  high in LOAD_FIRST_DATA; marks the header write to the FIFO
- ld_state  output  1  high in LOAD_DATA
- laf_state  output  1  high in LOAD_AFTER_FULL
- full_state  output  1  high in FIFO_FULL_STATE
- write_enb_reg  output  1  datapath byte write strobe
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR; clears the datapath's internal parity registers
- busy  output  1  source must hold its data
- addr_q  output  2  latched destination used to drive FIFO write-enable select

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - reset=1 at a clock edge moves state to DECODE_ADDRESS and sets addr_q=0.
  - Reset outputs: detect_add=1, every other output=0.
  - Reset mid-packet abandons the packet immediately.
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE).
- Priority of next-state terms, highest first:
  1. reset
  2. soft_reset[addr_q] in any state except DA -> DA
  3. the normal transitions below
- Transitions:
  - DA: pkt_valid & data_in!=3 & fifo_empty[data_in] -> LFD, addr_q<=data_in.
  - DA: pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WTE, addr_q<=data_in.
  - DA: otherwise stay. Invalid address 3 is ignored and the FSM stays in DA while pkt_valid is held.
  - WTE: fifo_empty[addr_q] -> LFD, else stay. A full FIFO is never written from this state.
  - LFD: -> LD unconditionally (exactly 1 cycle).
  - LD: fifo_full[addr_q] -> FFS. Else !pkt_valid -> LP. Else stay. Full takes priority over !pkt_valid in the same cycle.
  - FFS: !fifo_full[addr_q] -> LAF, else stay.
  - LAF: parity_done -> DA. Else low_pkt_valid -> LP. Else -> LD.
  - LP: -> CPE unconditionally.
  - CPE: fifo_full[addr_q] -> FFS, else DA.
- addr_q changes only on DA exits and reset. It is held through all other states, including the soft-reset abort.
- Output decode (combinational from state, no extra latency):
  - write_enb_reg = LD|LFD|LP|LAF.
  - busy = LFD|LP|FFS|LAF|WTE|CPE. busy=0 in DA and LD.
  - lfd_state asserts exactly one cycle per accepted packet. The FIFO delays it internally by one cycle to tag the header.
- fifo_full, fifo_empty and soft_reset bits of non-selected destinations are ignored outside DA.
- Back-to-back packets: CPE -> DA -> LFD is the minimum inter-packet gap (DA lasts ≥1 cycle).
- Implementation uses a registered state and a combinational next-state block. There are no latches and no unreachable states; illegal encodings recover to DA.

Test Plan:
- Normal packet: reset 1 cycle; pkt_valid=1, data_in=2'b01, fifo_empty=3'b111; 4 payload cycles then pkt_valid=0 -> state sequence DA, LFD, LD×4, LP, CPE, DA; addr_q=1; write_enb_reg high for 6 cycles; rst_int_reg one pulse; lfd_state one pulse.
- Busy destination: data_in=2'b10, fifo_empty=3'b011 for 5 cycles then 3'b111 -> WTE for 5 cycles with busy=1 and write_enb_reg=0, then LFD.
- Full mid-payload: in LD with fifo_full[addr_q]=1 for 3 cycles -> FFS 3 cycles (busy=1, write_enb_reg=0), then LAF. With parity_done=0, low_pkt_valid=0 -> LD. Repeat with low_pkt_valid=1 -> LP.
- Soft reset abort: in LD, addr_q=0, pulse soft_reset=3'b001 -> DA next cycle with detect_add=1. Pulsing soft_reset=3'b010 instead -> no effect.
- Invalid address and reset mid-packet: data_in=2'b11 with pkt_valid=1 for 4 cycles -> remains DA, write_enb_reg=0. Assert reset during FFS -> DA on the next edge with all outputs at reset values.
- Simultaneous events: in LD, fifo_full=1 and pkt_valid=0 in the same cycle -> FFS, not LP. In CPE with fifo_full[addr_q]=1 -> FFS.
